// File: rtl/vending_machine_multi.sv
// -----------------------------------------------------------------------------
// vending_machine_multi
// Multi-product vending controller with per-item prices, a saturating credit
// accumulator, valid/ready vend and change handshakes, greedy change return
// and a cancel/refund path.
//
// Optional feature macro: VM_INVENTORY_EN
//   defined   -> per-item stock counters, sold_out flags, sold-out refusals
//   undefined -> no stock tracking, sold_out tied low
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   coin_in      coin pulse: 00 none, 01 = 1 unit, 10 = 2 units, 11 = 5 units
//   sel_valid    one-cycle selection strobe
//   sel_item     selected item index
//   cancel       refund request strobe
//   vend_valid   dispense request          (registered)
//   vend_item    item being dispensed      (registered)
//   vend_ready   dispenser accepts
//   chg_valid    change coin request       (registered)
//   chg_coin     denomination to eject     (registered)
//   chg_ready    hopper accepts coin
//   credit       current credit in units   (registered)
//   coin_reject  pulse: coin not credited  (registered)
//   sel_denied   pulse: selection refused  (registered)
//   busy         state != ACCEPT           (registered)
//   sold_out     per-item empty flags      (registered)
// -----------------------------------------------------------------------------
module vending_machine_multi #(
    parameter int                         NUM_ITEMS  = 4,
    parameter int                         PRICE_W    = 6,
    parameter logic [NUM_ITEMS*PRICE_W-1:0] PRICES   = {6'd10, 6'd7, 6'd5, 6'd3},
    parameter int                         CREDIT_W   = 8,
    parameter int                         MAX_CREDIT = 20,
    parameter int                         STOCK_INIT = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   coin_in,
    input  logic                         sel_valid,
    input  logic [$clog2(NUM_ITEMS)-1:0] sel_item,
    input  logic                         cancel,
    output logic                         vend_valid,
    output logic [$clog2(NUM_ITEMS)-1:0] vend_item,
    input  logic                         vend_ready,
    output logic                         chg_valid,
    output logic [1:0]                   chg_coin,
    input  logic                         chg_ready,
    output logic [CREDIT_W-1:0]          credit,
    output logic                         coin_reject,
    output logic                         sel_denied,
    output logic                         busy,
    output logic [NUM_ITEMS-1:0]         sold_out
);

    localparam int IDX_W = $clog2(NUM_ITEMS);

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_VEND   = 2'd1,
        ST_CHANGE = 2'd2
    } state_e;

    if (MAX_CREDIT >= (2 ** CREDIT_W) || NUM_ITEMS < 2 || STOCK_INIT < 0) begin : g_param_check
        $error("vending_machine_multi: illegal parameter combination");
    end

    // Coin code to value in units.
    function automatic logic [2:0] coin_value(input logic [1:0] code);
        case (code)
            2'b01:   coin_value = 3'd1;
            2'b10:   coin_value = 3'd2;
            2'b11:   coin_value = 3'd5;
            default: coin_value = 3'd0;
        endcase
    endfunction

    // Largest denomination not exceeding the remaining credit.
    function automatic logic [1:0] greedy_coin(input logic [CREDIT_W-1:0] c);
        if (c >= CREDIT_W'(3'd5))      greedy_coin = 2'b11;
        else if (c >= CREDIT_W'(2'd2)) greedy_coin = 2'b10;
        else                           greedy_coin = 2'b01;
    endfunction

    // Price table lookup; out-of-range indices read as zero (they are refused anyway).
    function automatic logic [PRICE_W-1:0] price_of(input logic [IDX_W-1:0] idx);
        price_of = {PRICE_W{1'b0}};
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (idx == IDX_W'(i)) price_of = PRICES[i*PRICE_W +: PRICE_W];
            else                  price_of = price_of;
        end
    endfunction

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [IDX_W-1:0]    vend_item_q, vend_item_d;
    logic                vend_valid_q, vend_valid_d;
    logic                chg_valid_q, chg_valid_d;
    logic [1:0]          chg_coin_q, chg_coin_d;
    logic                coin_reject_q, coin_reject_d;
    logic                sel_denied_q, sel_denied_d;
    logic                busy_q, busy_d;

    logic [CREDIT_W:0]   coin_sum_s;
    logic                coin_fits_s;
    logic [PRICE_W-1:0]  price_s;
    logic                idx_ok_s;
    logic                afford_s;
    logic                avail_s;
    logic [CREDIT_W-1:0] chg_left_s;
    logic                taken_s;

    // One extra bit so the MAX_CREDIT comparison cannot wrap.
    assign coin_sum_s  = {1'b0, credit_q} + (CREDIT_W+1)'(coin_value(coin_in));
    assign coin_fits_s = (coin_sum_s <= (CREDIT_W+1)'(MAX_CREDIT));
    assign price_s     = price_of(sel_item);
    assign idx_ok_s    = (int'(sel_item) < NUM_ITEMS);
    assign afford_s    = (credit_q >= CREDIT_W'(price_s));
    assign chg_left_s  = credit_q - CREDIT_W'(coin_value(chg_coin_q));

`ifdef VM_INVENTORY_EN
    localparam int SW = $clog2(STOCK_INIT + 1);

    logic [SW-1:0]        stock_q [NUM_ITEMS];
    logic [SW-1:0]        stock_d [NUM_ITEMS];
    logic [NUM_ITEMS-1:0] sold_out_q, sold_out_d;

    assign avail_s  = (stock_q[sel_item] != {SW{1'b0}});
    assign sold_out = sold_out_q;

    // Stock decrements on the vend handshake; flags follow the new counts.
    always_comb begin
        stock_d = stock_q;
        if (state_q == ST_VEND && vend_ready) stock_d[vend_item_q] = stock_q[vend_item_q] - SW'(1'b1);
        else                                  stock_d = stock_q;
        for (int i = 0; i < NUM_ITEMS; i++) sold_out_d[i] = (stock_d[i] == {SW{1'b0}});
    end

    // Stock counters and sold-out flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= SW'(STOCK_INIT);
            sold_out_q <= {NUM_ITEMS{(STOCK_INIT == 0)}};
        end else begin
            stock_q    <= stock_d;
            sold_out_q <= sold_out_d;
        end
    end
`else
    assign avail_s  = 1'b1;
    assign sold_out = {NUM_ITEMS{1'b0}};
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        vend_item_d   = vend_item_q;
        vend_valid_d  = 1'b0;
        chg_valid_d   = 1'b0;
        chg_coin_d    = chg_coin_q;
        coin_reject_d = 1'b0;
        sel_denied_d  = 1'b0;
        taken_s       = 1'b0;
        case (state_q)
            ST_ACCEPT: begin
                // cancel > sel_valid > coin; an acted-on request swallows the coin.
                if (cancel && credit_q != {CREDIT_W{1'b0}}) begin
                    state_d     = ST_CHANGE;
                    chg_valid_d = 1'b1;
                    chg_coin_d  = greedy_coin(credit_q);
                    taken_s     = 1'b1;
                end else if (sel_valid) begin
                    if (idx_ok_s && afford_s && avail_s) begin
                        state_d      = ST_VEND;
                        credit_d     = credit_q - CREDIT_W'(price_s);
                        vend_item_d  = sel_item;
                        vend_valid_d = 1'b1;
                        taken_s      = 1'b1;
                    end else begin
                        sel_denied_d = 1'b1;
                    end
                end else begin
                    taken_s = 1'b0;
                end
                if (coin_in != 2'b00) begin
                    if (taken_s || !coin_fits_s) coin_reject_d = 1'b1;
                    else                         credit_d      = coin_sum_s[CREDIT_W-1:0];
                end else begin
                    coin_reject_d = 1'b0;
                end
            end
            ST_VEND: begin
                coin_reject_d = (coin_in != 2'b00);
                vend_valid_d  = 1'b1;
                if (vend_ready) begin
                    vend_valid_d = 1'b0;
                    if (credit_q != {CREDIT_W{1'b0}}) begin
                        state_d     = ST_CHANGE;
                        chg_valid_d = 1'b1;
                        chg_coin_d  = greedy_coin(credit_q);
                    end else begin
                        state_d = ST_ACCEPT;
                    end
                end else begin
                    state_d = ST_VEND;
                end
            end
            ST_CHANGE: begin
                coin_reject_d = (coin_in != 2'b00);
                chg_valid_d   = 1'b1;
                if (chg_ready) begin
                    credit_d = chg_left_s;
                    if (chg_left_s == {CREDIT_W{1'b0}}) begin
                        state_d     = ST_ACCEPT;
                        chg_valid_d = 1'b0;
                    end else begin
                        chg_coin_d = greedy_coin(chg_left_s);
                    end
                end else begin
                    state_d = ST_CHANGE;
                end
            end
            default: begin
                state_d = ST_ACCEPT;
            end
        endcase
        busy_d = (state_d != ST_ACCEPT);
    end

    // State and registered-output flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_ACCEPT;
            credit_q      <= {CREDIT_W{1'b0}};
            vend_item_q   <= {IDX_W{1'b0}};
            vend_valid_q  <= 1'b0;
            chg_valid_q   <= 1'b0;
            chg_coin_q    <= 2'b00;
            coin_reject_q <= 1'b0;
            sel_denied_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            vend_item_q   <= vend_item_d;
            vend_valid_q  <= vend_valid_d;
            chg_valid_q   <= chg_valid_d;
            chg_coin_q    <= chg_coin_d;
            coin_reject_q <= coin_reject_d;
            sel_denied_q  <= sel_denied_d;
            busy_q        <= busy_d;
        end
    end

    assign vend_valid  = vend_valid_q;
    assign vend_item   = vend_item_q;
    assign chg_valid   = chg_valid_q;
    assign chg_coin    = chg_coin_q;
    assign credit      = credit_q;
    assign coin_reject = coin_reject_q;
    assign sel_denied  = sel_denied_q;
    assign busy        = busy_q;

endmodule

// File: doc/vending_machine_multi.md
Name: vending_machine_multi

Overview:
Parametrised successor to the single-product vending controller. It supports NUM_ITEMS products, each with its own price, and three coin denominations. Credit is held in a saturating accumulator. Vending and change return each use a valid/ready handshake. Change is returned greedily as a stream of coins, and a cancel/refund path returns all credit. It sits between the coin acceptor front end and the dispenser/hopper drivers.

Parameters:
NUM_ITEMS, 4, number of selectable products (>=2)
PRICE_W, 6, bits per price entry; prices are in 5-cent units
PRICES, {6'd10,6'd7,6'd5,6'd3}, packed NUM_ITEMS*PRICE_W price table; item i is at [i*PRICE_W +: PRICE_W] (item0=3, item1=5, item2=7, item3=10)
CREDIT_W, 8, credit register width
MAX_CREDIT, 20, highest credit accepted in units; must be < 2**CREDIT_W
STOCK_INIT, 8, initial per-item stock (used only with VM_INVENTORY_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
coin_in  in  2  coin pulse, sampled every cycle: 00 none, 01=1 unit, 10=2 units, 11=5 units
sel_valid  in  1  one-cycle selection strobe
sel_item  in  $clog2(NUM_ITEMS)  selected item index
cancel  in  1  refund request strobe
vend_valid  out  1  dispense request
vend_item  out  $clog2(NUM_ITEMS)  item being dispensed
vend_ready  in  1  dispenser accepts
chg_valid  out  1  change coin request
chg_coin  out  2  denomination to eject (01/10/11 encoding)
chg_ready  in  1  hopper accepts coin
credit  out  CREDIT_W  current credit in units
coin_reject  out  1  one-cycle pulse: the coin was not credited
sel_denied  out  1  one-cycle pulse: the selection was refused
busy  out  1  high when state != ACCEPT
sold_out  out  NUM_ITEMS  per-item empty flags

Behaviour:
- Reset (synchronous, wins over all inputs):
  - state=ACCEPT, credit=0.
  - All outputs 0.
  - Stock=STOCK_INIT. Reset mid-VEND/CHANGE drops the transaction with no refund.
- States: ACCEPT, VEND, CHANGE. All outputs are registered.
- ACCEPT, input priority per cycle is cancel > sel_valid > coin:
  - cancel with credit>0 -> CHANGE. cancel with credit==0 is ignored.
  - sel_valid refused if: index >= NUM_ITEMS, credit < price, or the item is sold out. A refusal pulses sel_denied next cycle and leaves state and credit unchanged.
  - sel_valid accepted -> credit -= price, vend_item latched, VEND. vend_valid is asserted the cycle after sel_valid (latency 1).
  - Coin: if credit+value <= MAX_CREDIT, add it. Otherwise pulse coin_reject next cycle and leave credit unchanged.
  - A coin in the same cycle as an acted-on cancel or accepted selection is rejected.
  - A coin in the same cycle as a refused selection is still evaluated normally.
- VEND:
  - vend_valid=1; vend_item is held stable until the handshake.
  - On vend_valid&vend_ready: vend_valid drops the next cycle; go to CHANGE if credit>0, else ACCEPT.
  - Coins are rejected (coin_reject). sel_valid and cancel are ignored; no sel_denied is raised.
- CHANGE:
  - chg_valid=1; chg_coin = largest denomination <= credit (11 if >=5, 10 if >=2, else 01).
  - chg_coin is stable while chg_ready is low.
  - On handshake: credit -= value. Go to ACCEPT when credit reaches 0, otherwise present the next coin in the following cycle with no bubble required.
  - Coins are rejected; sel/cancel are ignored.
- Arithmetic: unsigned. Credit can never underflow because the price check precedes subtraction. The MAX_CREDIT check uses a CREDIT_W+1 bit sum.
- busy = (state != ACCEPT).

Optional Feature:
VM_INVENTORY_EN:
- Defined:
  - Per-item stock counters $clog2(STOCK_INIT+1) bits wide, loaded to STOCK_INIT on reset.
  - Counters decrement on the vend handshake.
  - sold_out[i] = (stock[i]==0), registered.
  - Selecting a sold-out item -> sel_denied, with no credit change.
- Undefined: no counters; sold_out tied to 0; every valid index is always available.

Test Plan:
1. Coins 11,01 (credit 6); select item1 -> vend_valid=1, vend_item=1 next cycle, credit=1; after vend_ready, one chg_coin=01 handshake, credit=0, busy=0.
2. Coins 11,10 (credit 7); select item3 (price 10) -> sel_denied pulse, credit 7. Then cancel -> chg_coin 11 then 10; with chg_ready held low 3 cycles, chg_coin stays 11; final credit 0.
3. Four 11 coins (credit 20); a 01 coin -> coin_reject pulse, credit stays 20. During VEND, any coin -> coin_reject.
4. coin_in=10 in the same cycle as an accepted sel_valid for item0 with credit 3 -> coin_reject pulse, credit 0, no change phase.
5. Assert rst for 1 cycle while chg_valid=1 with credit 4 -> next cycle all outputs 0, state ACCEPT, credit 0; coins are then accepted normally.
6. With VM_INVENTORY_EN and STOCK_INIT=1: buy item0 twice with 3 units each -> first vends and sold_out[0]=1 after the handshake; second gives sel_denied, credit remains 3.
